// File: rtl/op_serializer_if.sv
// Handshake and serial-line bundle between the op encoder and op_serializer.
// The encoder side drives the packet and its valid level; the serializer drives the rest.
interface op_serializer_if;
  logic [39:0] data;
  logic        data_valid;
  logic        data_taken;
  logic        busy;
  logic        serial_out;

  modport master (
    output data,
    output data_valid,
    input  data_taken,
    input  busy,
    input  serial_out
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_taken,
    output busy,
    output serial_out
  );
endinterface

// File: rtl/op_serializer.sv
// Serializes one 40-bit op packet MSB first onto a single idle-high wire,
// framed by a one-bit-time start bit and a GAP_BITS idle gap.
module op_serializer #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned GAP_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  op_serializer_if.slave  bus
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [5:0]    BIT_LAST = 6'd39;
  localparam logic [5:0]    GAP_LAST = 6'(GAP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    GAP
  } state_e;

  state_e          state_q, state_d;
  logic [39:0]     sreg_q,  sreg_d;
  logic [CW-1:0]   cyc_q,   cyc_d;
  logic [5:0]      bit_q,   bit_d;
  logic            taken_q, taken_d;
  logic            busy_q,  busy_d;
  logic            sout_q,  sout_d;
  logic            boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cyc_q   <= '0;
      bit_q   <= '0;
      taken_q <= 1'b0;
      busy_q  <= 1'b0;
      sout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      taken_q <= taken_d;
      busy_q  <= busy_d;
      sout_q  <= sout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    taken_d  = 1'b0;
    boundary = (cyc_q == CYC_LAST);

    if (state_q != IDLE) begin
      cyc_d = boundary ? '0 : cyc_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Packet is frozen here; data is never looked at outside this edge.
        if (bus.data_valid) begin
          state_d = START;
          sreg_d  = bus.data;
          cyc_d   = '0;
          bit_d   = '0;
          taken_d = 1'b1;
        end
      end
      START: begin
        if (boundary) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (boundary) begin
          sreg_d = {sreg_q[38:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            state_d = GAP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (boundary) begin
          if (bit_q == GAP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase

    // Outputs are decoded from next state so they land in flops aligned with it.
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = sreg_d[39];
      default: sout_d = 1'b1;
    endcase
  end

  assign bus.data_taken = taken_q;
  assign bus.busy       = busy_q;
  assign bus.serial_out = sout_q;

endmodule
